// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader: FSM state encodings,
// byte/word geometry and the default halt encoding.
package instr_mem_loader_pkg;

    localparam int          BYTE_W         = 8;
    localparam int          BYTES_PER_WORD = 4;
    localparam logic [31:0] DEF_HALT_WORD  = 32'hFFFF_FFFF;

    typedef logic [2:0] loader_state_t;

    localparam loader_state_t ST_IDLE  = 3'd0;
    localparam loader_state_t ST_RECV  = 3'd1;
    localparam loader_state_t ST_WRITE = 3'd2;
    localparam loader_state_t ST_CHK   = 3'd3;
    localparam loader_state_t ST_DONE  = 3'd4;

    function automatic int bytes_per_word(input int size_word);
        return size_word / BYTE_W;
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects a big-endian byte stream into SIZE_WORD-bit words; word_valid
// flags the byte that completes a word, the finished word is visible next cycle.
module word_assembler
    import instr_mem_loader_pkg::*;
#(
    parameter int SIZE_WORD = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic                 i_byte_valid,
    input  logic [BYTE_W-1:0]    i_byte,
    output logic [SIZE_WORD-1:0] o_word,
    output logic                 o_word_valid
);

    localparam int BPW   = bytes_per_word(SIZE_WORD);
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

    logic [IDX_W-1:0]     idx_r;
    logic [SIZE_WORD-1:0] word_r;

    assign o_word       = word_r;
    assign o_word_valid = i_byte_valid & (idx_r == LAST_IDX);

    // Byte index counter and MSB-first shift register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            idx_r  <= '0;
            word_r <= '0;
        end else if (i_clear) begin
            idx_r  <= '0;
            word_r <= '0;
        end else if (i_byte_valid) begin
            word_r <= {word_r[SIZE_WORD-BYTE_W-1:0], i_byte};
            idx_r  <= (idx_r == LAST_IDX) ? '0 : idx_r + IDX_W'(1);
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a program from the UART byte stream into instruction memory.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and o_chk_err.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int                   SIZE_PC   = 32,
    parameter int                   SIZE_WORD = 32,
    parameter int                   MEM_DEPTH = 256,
    parameter logic [SIZE_WORD-1:0] HALT_WORD = DEF_HALT_WORD
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_load_req,
    input  logic [7:0]                     i_rx_data,
    input  logic                           i_rx_valid,
    output logic                           o_rx_ready,
    output logic                           o_mem_wr_en,
    output logic [SIZE_PC-1:0]             o_mem_addr,
    output logic [SIZE_WORD-1:0]           o_mem_wr_data,
    output logic                           o_loading,
    output logic                           o_load_done,
    output logic                           o_overflow,
    output logic [$clog2(MEM_DEPTH+1)-1:0] o_word_count
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic                           o_chk_err
`endif
);

    localparam int CNT_W = $clog2(MEM_DEPTH + 1);
    localparam int BPW   = bytes_per_word(SIZE_WORD);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(MEM_DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(MEM_DEPTH - 1);

    loader_state_t        state_r;
    loader_state_t        state_nxt_s;
    logic [SIZE_PC-1:0]   addr_r;
    logic [CNT_W-1:0]     count_r;
    logic                 ovf_r;
    logic                 rx_ready_r;
    logic                 wr_en_r;
    logic                 loading_r;
    logic                 done_r;
    logic                 accept_s;
    logic                 data_accept_s;
    logic                 word_valid_s;
    logic                 is_halt_s;
    logic [SIZE_WORD-1:0] word_s;

    // A restart in the same cycle as a handshake drops the byte.
    assign accept_s      = i_rx_valid & rx_ready_r & ~i_load_req;
    assign data_accept_s = accept_s & (state_r == ST_RECV);
    assign is_halt_s     = (word_s == HALT_WORD);

    word_assembler #(
        .SIZE_WORD(SIZE_WORD)
    ) u_word_assembler (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (i_load_req),
        .i_byte_valid(data_accept_s),
        .i_byte      (i_rx_data),
        .o_word      (word_s),
        .o_word_valid(word_valid_s)
    );

    // Next-state decode; a load request overrides every state.
    always_comb begin
        state_nxt_s = state_r;
        if (i_load_req) begin
            state_nxt_s = ST_RECV;
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt_s = ST_IDLE;
                ST_RECV:  state_nxt_s = word_valid_s ? ST_WRITE : ST_RECV;
                ST_WRITE: begin
                    if (is_halt_s) begin
`ifdef LOADER_CHECKSUM_EN
                        state_nxt_s = ST_CHK;
`else
                        state_nxt_s = ST_DONE;
`endif
                    end else if (count_r == LAST_CNT) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RECV;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHK:   state_nxt_s = accept_s ? ST_DONE : ST_CHK;
`endif
                ST_DONE:  state_nxt_s = ST_DONE;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State, registered status outputs, write address and word count.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r    <= ST_IDLE;
            rx_ready_r <= 1'b0;
            wr_en_r    <= 1'b0;
            loading_r  <= 1'b0;
            done_r     <= 1'b0;
            addr_r     <= '0;
            count_r    <= '0;
            ovf_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            rx_ready_r <= (state_nxt_s == ST_RECV) || (state_nxt_s == ST_CHK);
            wr_en_r    <= (state_nxt_s == ST_WRITE);
            loading_r  <= (state_nxt_s == ST_RECV) || (state_nxt_s == ST_WRITE) ||
                          (state_nxt_s == ST_CHK);
            done_r     <= (state_nxt_s == ST_DONE);
            if (i_load_req) begin
                addr_r  <= '0;
                count_r <= '0;
                ovf_r   <= 1'b0;
            end else if (state_r == ST_WRITE) begin
                addr_r <= addr_r + SIZE_PC'(BPW);
                if (count_r != DEPTH_CNT) begin
                    count_r <= count_r + CNT_W'(1);
                end
                if (!is_halt_s && (count_r == LAST_CNT)) begin
                    ovf_r <= 1'b1;
                end
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] chk_r;
    logic       chk_err_r;

    // Running XOR of data bytes, compared against the trailing checksum byte.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            chk_r     <= 8'h00;
            chk_err_r <= 1'b0;
        end else if (i_load_req) begin
            chk_r     <= 8'h00;
            chk_err_r <= 1'b0;
        end else if (data_accept_s) begin
            chk_r <= chk_r ^ i_rx_data;
        end else if ((state_r == ST_CHK) && accept_s) begin
            chk_err_r <= (i_rx_data != chk_r);
        end
    end

    assign o_chk_err = chk_err_r;
`endif

    assign o_rx_ready    = rx_ready_r;
    assign o_mem_wr_en   = wr_en_r;
    assign o_mem_addr    = addr_r;
    assign o_mem_wr_data = word_s;
    assign o_loading     = loading_r;
    assign o_load_done   = done_r;
    assign o_overflow    = ovf_r;
    assign o_word_count  = count_r;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader (MEM_DEPTH=4): per-cycle vector table
// plus hand-written overflow, reset and checksum sequences.
module tb_instr_mem_loader;

    localparam int TB_DEPTH = 4;
    localparam int CNT_W    = $clog2(TB_DEPTH + 1);

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic             i_load_req;
    logic [7:0]       i_rx_data;
    logic             i_rx_valid;
    logic             o_rx_ready;
    logic             o_mem_wr_en;
    logic [31:0]      o_mem_addr;
    logic [31:0]      o_mem_wr_data;
    logic             o_loading;
    logic             o_load_done;
    logic             o_overflow;
    logic [CNT_W-1:0] o_word_count;
`ifdef LOADER_CHECKSUM_EN
    logic             o_chk_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    typedef struct {
        logic        req;
        logic        valid;
        logic [7:0]  data;
        logic        rdy;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ld;
        logic        dn;
        logic        ov;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    instr_mem_loader #(
        .MEM_DEPTH(TB_DEPTH)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_load_req   (i_load_req),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_rx_ready   (o_rx_ready),
        .o_mem_wr_en  (o_mem_wr_en),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wr_data(o_mem_wr_data),
        .o_loading    (o_loading),
        .o_load_done  (o_load_done),
        .o_overflow   (o_overflow),
        .o_word_count (o_word_count)
`ifdef LOADER_CHECKSUM_EN
        ,
        .o_chk_err    (o_chk_err)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic req, input logic valid, input logic [7:0] data,
                                input logic rdy, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic ld, input logic dn,
                                input logic ov, input logic [2:0] cnt);
        vec_t v;
        v.req = req; v.valid = valid; v.data = data; v.rdy = rdy; v.wr = wr;
        v.addr = addr; v.wdata = wdata; v.ld = ld; v.dn = dn; v.ov = ov; v.cnt = cnt;
        return v;
    endfunction

    // Write monitor; sampled on the falling edge, away from the active edge.
    always @(negedge i_clk) begin
        if (!i_reset && o_mem_wr_en) begin
            wr_addr_q.push_back(o_mem_addr);
            wr_data_q.push_back(o_mem_wr_data);
            check("ready_low_during_write", {63'd0, o_rx_ready}, 64'd0);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit sent = 1'b0;
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        for (int k = 0; k < 20 && !sent; k++) begin
            if (o_rx_ready) sent = 1'b1;
            @(posedge i_clk); #1;
        end
        i_rx_valid = 1'b0;
        n_checks++;
        if (!sent) begin
            n_fail++;
            $display("FAIL send_byte_timeout: byte %0h got ready=0 expected ready=1", b);
        end
    endtask

    task automatic pulse_req();
        i_load_req = 1'b1;
        @(posedge i_clk); #1;
        i_load_req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},   {63'd0, o_rx_ready},  64'd0);
        check({tag, "_wr_en"},   {63'd0, o_mem_wr_en}, 64'd0);
        check({tag, "_addr"},    {32'd0, o_mem_addr},  64'd0);
        check({tag, "_wdata"},   {32'd0, o_mem_wr_data}, 64'd0);
        check({tag, "_loading"}, {63'd0, o_loading},   64'd0);
        check({tag, "_done"},    {63'd0, o_load_done}, 64'd0);
        check({tag, "_ovf"},     {63'd0, o_overflow},  64'd0);
        check({tag, "_count"},   64'(o_word_count),    64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Two-word load with valid held high, then a restart that drops a partial word.
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h20, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0, 3'd0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h08, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0, 3'd0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0, 3'd0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0, 3'd0));
        vecs.push_back(mk(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 32'h0, 32'h20080005, 1'b1, 1'b0, 1'b0, 3'd0));
        vecs.push_back(mk(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 32'h4, 32'h0,        1'b1, 1'b0, 1'b0, 3'd1));
        vecs.push_back(mk(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 32'h4, 32'h0,        1'b1, 1'b0, 1'b0, 3'd1));
        vecs.push_back(mk(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 32'h4, 32'h0,        1'b1, 1'b0, 1'b0, 3'd1));
        vecs.push_back(mk(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 32'h4, 32'h0,        1'b1, 1'b0, 1'b0, 3'd1));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h4, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 3'd1));
`ifdef LOADER_CHECKSUM_EN
        vecs.push_back(mk(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 32'h8, 32'h0,        1'b1, 1'b0, 1'b0, 3'd2));
`else
        vecs.push_back(mk(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 32'h8, 32'h0,        1'b0, 1'b1, 1'b0, 3'd2));
`endif
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h8, 32'h0,        1'b0, 1'b1, 1'b0, 3'd2));
        vecs.push_back(mk(1'b1, 1'b1, 8'hAB, 1'b0, 1'b0, 32'h8, 32'h0,        1'b0, 1'b1, 1'b0, 3'd2));
        vecs.push_back(mk(1'b0, 1'b1, 8'hAB, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0, 3'd0));
        vecs.push_back(mk(1'b0, 1'b1, 8'hCD, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0, 3'd0));
        vecs.push_back(mk(1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0, 3'd0));
        vecs.push_back(mk(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0, 3'd0));
        vecs.push_back(mk(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0, 3'd0));
        vecs.push_back(mk(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0, 3'd0));
        vecs.push_back(mk(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0, 3'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 3'd0));
`ifdef LOADER_CHECKSUM_EN
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h4, 32'h0,        1'b1, 1'b0, 1'b0, 3'd1));
`else
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h4, 32'h0,        1'b0, 1'b1, 1'b0, 3'd1));
`endif

        i_reset = 1'b1; i_load_req = 1'b0; i_rx_valid = 1'b0; i_rx_data = 8'h00;
        repeat (3) @(posedge i_clk);
        #1;
        check_all_zero("reset");
        i_reset = 1'b0;
        @(posedge i_clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            i_load_req = vecs[i].req;
            i_rx_valid = vecs[i].valid;
            i_rx_data  = vecs[i].data;
            check($sformatf("row%0d_ready", i),   {63'd0, o_rx_ready},  {63'd0, vecs[i].rdy});
            check($sformatf("row%0d_wr_en", i),   {63'd0, o_mem_wr_en}, {63'd0, vecs[i].wr});
            if (vecs[i].wr) begin
                check($sformatf("row%0d_addr", i),  {32'd0, o_mem_addr},    {32'd0, vecs[i].addr});
                check($sformatf("row%0d_wdata", i), {32'd0, o_mem_wr_data}, {32'd0, vecs[i].wdata});
            end
            check($sformatf("row%0d_loading", i), {63'd0, o_loading},   {63'd0, vecs[i].ld});
            check($sformatf("row%0d_done", i),    {63'd0, o_load_done}, {63'd0, vecs[i].dn});
            check($sformatf("row%0d_ovf", i),     {63'd0, o_overflow},  {63'd0, vecs[i].ov});
            check($sformatf("row%0d_count", i),   64'(o_word_count),    64'(vecs[i].cnt));
            @(posedge i_clk); #1;
        end
        i_load_req = 1'b0; i_rx_valid = 1'b0;

        // Overflow: fill all four words without a halt word.
        wr_addr_q.delete(); wr_data_q.delete();
        pulse_req();
        for (int w = 0; w < TB_DEPTH; w++) begin
            send_byte(8'h10 + 8'(w));
            send_byte(8'h20 + 8'(w));
            send_byte(8'h30 + 8'(w));
            send_byte(8'h40 + 8'(w));
        end
        repeat (2) @(posedge i_clk);
        #1;
        check("ovf_flag",    {63'd0, o_overflow},  64'd1);
        check("ovf_done",    {63'd0, o_load_done}, 64'd1);
        check("ovf_loading", {63'd0, o_loading},   64'd0);
        check("ovf_count",   64'(o_word_count),    64'd4);
        i_rx_valid = 1'b1; i_rx_data = 8'h55;
        for (int k = 0; k < 3; k++) begin
            check("ovf_no_accept", {63'd0, o_rx_ready}, 64'd0);
            @(posedge i_clk); #1;
        end
        i_rx_valid = 1'b0;
        check("ovf_write_count", 64'(wr_addr_q.size()), 64'd4);
        for (int w = 0; w < TB_DEPTH; w++) begin
            if (w < wr_addr_q.size()) begin
                check($sformatf("ovf_addr%0d", w), {32'd0, wr_addr_q[w]}, 64'(4 * w));
                check($sformatf("ovf_data%0d", w), {32'd0, wr_data_q[w]},
                      {32'd0, 8'h10 + 8'(w), 8'h20 + 8'(w), 8'h30 + 8'(w), 8'h40 + 8'(w)});
            end
        end

        // Asynchronous reset in the middle of a word.
        pulse_req();
        send_byte(8'hAA);
        send_byte(8'hBB);
        #3;
        i_reset = 1'b1;
        #1;
        check_all_zero("midreset");
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        #1;
        check_all_zero("postreset");
        wr_addr_q.delete(); wr_data_q.delete();
        @(posedge i_clk); #1;
        pulse_req();
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        for (int k = 0; k < 4; k++) send_byte(8'hFF);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h08);
`endif
        @(posedge i_clk); #1;
        check("reload_done",   {63'd0, o_load_done}, 64'd1);
        check("reload_writes", 64'(wr_addr_q.size()), 64'd2);
        if (wr_addr_q.size() >= 2) begin
            check("reload_addr0", {32'd0, wr_addr_q[0]}, 64'h0);
            check("reload_data0", {32'd0, wr_data_q[0]}, 64'h12345678);
            check("reload_addr1", {32'd0, wr_addr_q[1]}, 64'h4);
            check("reload_data1", {32'd0, wr_data_q[1]}, 64'hFFFFFFFF);
        end

`ifdef LOADER_CHECKSUM_EN
        // Checksum: XOR of 01,02,03,04,FF,FF,FF,FF is 04.
        for (int pass = 0; pass < 2; pass++) begin
            pulse_req();
            check("chk_cleared", {63'd0, o_chk_err}, 64'd0);
            for (int b = 1; b <= 4; b++) send_byte(8'(b));
            for (int k = 0; k < 4; k++) send_byte(8'hFF);
            check("chk_wait_done", {63'd0, o_load_done}, 64'd0);
            send_byte((pass == 0) ? 8'h04 : 8'h05);
            check("chk_done", {63'd0, o_load_done}, 64'd1);
            check("chk_err",  {63'd0, o_chk_err},   64'(pass));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Writer side of the instruction memory read by the fetch stage: accepts a program as a byte stream from the UART receiver, assembles big-endian 32-bit words and writes them to consecutive byte addresses starting at 0. Loading ends on the halt word or when memory is full. `o_load_done` then tells the debug/control logic that the PC may be started.

## Interface
Parameters:
- `SIZE_PC`, 32, address width (byte address, same as PC)
- `SIZE_WORD`, 32, instruction word width (multiple of 8)
- `MEM_DEPTH`, 256, instruction memory depth in words
- `HALT_WORD`, 32'hFFFF_FFFF, encoding that terminates a load

Ports (one clock; reset asynchronous, active-high):
- `i_clk` in 1: clock, rising edge
- `i_reset` in 1: async active-high reset
- `i_load_req` in 1: single-cycle pulse, starts or restarts a load
- `i_rx_data` in 8: byte from UART receiver
- `i_rx_valid` in 1: `i_rx_data` valid
- `o_rx_ready` out 1: loader accepts a byte this cycle
- `o_mem_wr_en` out 1: instruction memory write strobe
- `o_mem_addr` out SIZE_PC: byte address of the write (word-aligned)
- `o_mem_wr_data` out SIZE_WORD: word to write
- `o_loading` out 1: load in progress
- `o_load_done` out 1: load finished (level, held until next `i_load_req`)
- `o_overflow` out 1: memory filled without halt word
- `o_word_count` out $clog2(MEM_DEPTH+1): words written in current load
- `o_chk_err` out 1: checksum mismatch (only with `LOADER_CHECKSUM_EN`)

## Operation
- States: IDLE, RECV, WRITE, CHK (only with `LOADER_CHECKSUM_EN`), DONE.
- IDLE: `o_rx_ready`=0. `i_load_req` moves to RECV and clears the address, word count, byte index, overflow, done and checksum.
- RECV: `o_rx_ready`=1. A byte transfers on `i_rx_valid & o_rx_ready`. The first byte goes in bits [SIZE_WORD-1:SIZE_WORD-8] (MSB first). The byte index runs 0..SIZE_WORD/8-1. When the last byte is accepted, go to WRITE.
- WRITE: one cycle, `o_mem_wr_en`=1, `o_rx_ready`=0. Address = 4 × word count. After the write the word count increments and the next address is +4.
  - Word == HALT_WORD (the halt word is written): go to CHK if the macro is defined, else DONE.
  - Word count reaches MEM_DEPTH without a halt word: go to DONE and set `o_overflow`=1.
  - Otherwise: back to RECV.
- DONE: `o_load_done`=1, `o_rx_ready`=0. Incoming bytes are ignored (not accepted).
- `i_load_req` in any state restarts in RECV with all counters cleared. A partial word is discarded. `o_load_done`, `o_overflow` and `o_chk_err` clear.
- `o_loading`=1 in RECV, WRITE and CHK.
- `o_word_count` saturates at MEM_DEPTH. The address never wraps.

## Timing
- Reset values: all outputs 0, state IDLE, internal registers 0.
- `i_load_req` in cycle N: `o_rx_ready`=1 in N+1.
- Last byte of a word accepted in cycle N: `o_mem_wr_en` high in N+1 only, and `o_rx_ready`=1 again in N+2 if continuing.
  - Throughput: 4 bytes per 5 cycles at best.
- Halt word write in cycle N: `o_load_done`=1 from N+1 (no checksum), or from the cycle after the checksum byte is accepted (checksum enabled).
- `i_load_req` coincident with a byte handshake: the restart wins and the byte is dropped.
- Reset asserted mid-load: outputs go to 0 immediately (async). The memory write in progress is aborted.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - The loader keeps an 8-bit XOR of every accepted data byte, including the halt word.
  - After the halt word it enters CHK and accepts exactly one more byte.
  - `o_chk_err` = (byte != running XOR). It is registered, valid with `o_load_done`.
  - The overflow path skips CHK.
- `LOADER_CHECKSUM_EN` undefined: no CHK state, no checksum logic, and the `o_chk_err` port is absent.

## Structure
- Shared package (pipeline package): the state enum, `HALT_WORD` default, instruction byte width (8), and bytes-per-word constant.
- One sub-module, `word_assembler`: a byte-index counter plus shift register with a `clear` input and a `word_valid` pulse. The FSM, address and count logic stay in `instr_mem_loader`.

## Test plan
- Load 2 words: bytes 20,08,00,05 then FF,FF,FF,FF after `i_load_req`.
  - Writes 0x20080005 @0x0, then 0xFFFFFFFF @0x4.
  - `o_word_count`=2, `o_load_done`=1, `o_overflow`=0.
- Hold `i_rx_valid` high continuously: exactly one `o_mem_wr_en` per 4 bytes, and `o_rx_ready`=0 during each WRITE cycle.
- MEM_DEPTH=4, send 4 non-halt words:
  - Writes at 0x0, 0x4, 0x8, 0xC.
  - Then `o_overflow`=1, `o_load_done`=1, and the next byte is not accepted.
- Send 2 bytes, pulse `i_load_req`, then a full halt word: single write 0xFFFFFFFF @0x0, and the partial bytes never appear.
- Assert `i_reset` mid-word, release it, then pulse `i_load_req`:
  - All outputs 0 during reset.
  - The following load starts at 0x0.
- With `LOADER_CHECKSUM_EN`, load 01,02,03,04 + FF×4:
  - Checksum byte 0x04 gives `o_chk_err`=0.
  - Checksum byte 0x05 gives `o_chk_err`=1.
